// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a 6-digit, 4-bit-per-digit
// 7-segment display. Walks digits 5..0, selecting each through an external 6:1
// mux. Each digit slot is a blank gap followed by a lit interval. The sampled
// value is decoded to segments.
//
// Optional feature macro: SEG_SCAN_LZS_EN (leading-zero suppression). When it is
// undefined, every digit is shown as decoded and no suppression state exists.
//
// Handshake / timing contract with the digit mux: mux_sel is registered and
// changes only on entry to BLANK. mux_data is a combinational return of mux_sel.
// It is sampled, together with blank_mask/dp_mask, on the last BLANK cycle, so
// the mux path has BLANK_CYC cycles to settle. There is no valid/ready pairing;
// the scan free-runs while en is high.
//
// The FSM state is held in state_q (type state_e) for hierarchical observation.
module seg_scan_ctrl #(
  parameter int SHOW_CYC   = 50000,
  parameter int BLANK_CYC  = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       RSTn,
  input  logic       en,
  output logic [2:0] mux_sel,
  input  logic [3:0] mux_data,
  input  logic [5:0] blank_mask,
  input  logic [5:0] dp_mask,
  output logic [7:0] seg,
  output logic [5:0] digit_en,
  output logic       frame_done
);

  localparam int MAX_CYC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // Idle levels of the pin drivers depend on board polarity.
  localparam logic [7:0] SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [5:0] DEN_OFF = (ACTIVE_LOW != 0) ? 6'h3F : 6'h00;
  localparam logic [2:0] PTR_FIRST = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       mux_sel_q, mux_sel_d;
  logic [7:0]       seg_q, seg_d;
  logic [5:0]       den_q, den_d;
  logic             fd_q, fd_d;

  // Segment pattern (active-high, {g,f,e,d,c,b,a}) for a hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic lzs_kill;

`ifdef SEG_SCAN_LZS_EN
  // nz: a nonzero digit has already been sampled in the current frame.
  logic nz_q, nz_d;
  logic sample_now, frame_restart;

  // Track whether leading zeros are still being scanned in this frame.
  always_comb begin
    sample_now    = en && (state_q == BLANK) && (cnt_q == BLANK_LAST);
    frame_restart = !en || (state_q == IDLE) ||
                    ((state_q == SHOW) && (cnt_q == SHOW_LAST) && (ptr_q == 3'd0));
    nz_d = nz_q;
    if (frame_restart) begin
      nz_d = 1'b0;
    end else if (sample_now && (mux_data != 4'h0)) begin
      nz_d = 1'b1;
    end
    // Digit 0 always shows, so a lone zero still reads "0".
    lzs_kill = !nz_q && (mux_data == 4'h0) && (ptr_q != 3'd0);
  end

  // Leading-zero flag register.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      nz_q <= 1'b0;
    end else begin
      nz_q <= nz_d;
    end
  end
`else
  assign lzs_kill = 1'b0;
`endif

  logic [6:0] seg_abc;
  logic [7:0] seg_act;
  logic [7:0] seg_drv;
  logic [5:0] den_act;
  logic [5:0] den_drv;

  // Decode the sampled digit into pin levels for the slot at ptr_q.
  always_comb begin
    seg_abc = hex7(mux_data);
    if (blank_mask[ptr_q] || lzs_kill) begin
      seg_abc = 7'h00;
    end
    // dp follows dp_mask even when a-g are blanked.
    seg_act = {dp_mask[ptr_q], seg_abc};
    seg_drv = (ACTIVE_LOW != 0) ? ~seg_act : seg_act;
    den_act = 6'b000001 << ptr_q;
    den_drv = (ACTIVE_LOW != 0) ? ~den_act : den_act;
  end

  // Next-state and registered-output logic for the scan FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    mux_sel_d = mux_sel_q;
    seg_d     = seg_q;
    den_d     = den_q;
    fd_d      = 1'b0;

    if (!en) begin
      // Dropping en abandons the frame; the next enable starts at digit 5.
      state_d   = IDLE;
      cnt_d     = CNT_ZERO;
      ptr_d     = PTR_FIRST;
      mux_sel_d = PTR_FIRST;
      seg_d     = SEG_OFF;
      den_d     = DEN_OFF;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = BLANK;
          cnt_d     = CNT_ZERO;
          ptr_d     = PTR_FIRST;
          mux_sel_d = PTR_FIRST;
          seg_d     = SEG_OFF;
          den_d     = DEN_OFF;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            // Capture the settled mux value and light this digit.
            state_d = SHOW;
            cnt_d   = CNT_ZERO;
            seg_d   = seg_drv;
            den_d   = den_drv;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = BLANK;
            cnt_d   = CNT_ZERO;
            seg_d   = SEG_OFF;
            den_d   = DEN_OFF;
            if (ptr_q == 3'd0) begin
              ptr_d     = PTR_FIRST;
              mux_sel_d = PTR_FIRST;
              fd_d      = 1'b1;
            end else begin
              ptr_d     = ptr_q - 3'd1;
              mux_sel_d = ptr_q - 3'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d   = IDLE;
          cnt_d     = CNT_ZERO;
          ptr_d     = PTR_FIRST;
          mux_sel_d = PTR_FIRST;
          seg_d     = SEG_OFF;
          den_d     = DEN_OFF;
        end
      endcase
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_ZERO;
      ptr_q     <= PTR_FIRST;
      mux_sel_q <= PTR_FIRST;
      seg_q     <= SEG_OFF;
      den_q     <= DEN_OFF;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      mux_sel_q <= mux_sel_d;
      seg_q     <= seg_d;
      den_q     <= den_d;
      fd_q      <= fd_d;
    end
  end

  assign mux_sel    = mux_sel_q;
  assign seg        = seg_q;
  assign digit_en   = den_q;
  assign frame_done = fd_q;

endmodule
